// File: rtl/shk_gray_mstr.sv
// rtl/shk_gray_mstr.sv - SHK gray-drive initiator: one command per SHK transaction, watchdog, sticky err bits
// Request port feeds a three-state IDLE/SEND/GAP sequencer; responses are single-cycle strobes.
module shk_gray_mstr #(
  parameter int NB_VER      = 0,
  parameter int WD_SHK_SYNC = 16,
  parameter int WD_SHK_DLAY = 15,
  parameter int WD_TOUT     = 16,
  parameter int NB_TOUT     = 1000,
  parameter int WD_ERR_INFO = 4
) (
  input  logic                   s_sys_a_clock,
  input  logic                   s_sys_a_resetn,
  input  logic                   s_cmd_valid,
  output logic                   s_cmd_ready,
  input  logic [WD_SHK_SYNC-1:0] s_cmd_sync,
  input  logic [WD_SHK_DLAY-1:0] s_cmd_dlay,
  output logic                   m_rsp_valid,
  output logic [WD_SHK_SYNC-1:0] m_rsp_sync,
  output logic [WD_SHK_DLAY-1:0] m_rsp_dlay,
  output logic                   m_rsp_tout,
  output logic                   m_shk_gray_wvalid,
  output logic [WD_SHK_SYNC-1:0] m_shk_gray_smosi,
  output logic [WD_SHK_DLAY-1:0] m_shk_gray_dmosi,
  input  logic                   m_shk_gray_wready,
  input  logic [WD_SHK_SYNC-1:0] m_shk_gray_smiso,
  input  logic [WD_SHK_DLAY-1:0] m_shk_gray_dmiso,
  input  logic [WD_ERR_INFO-1:0] s_err_gray_info1,
  output logic [WD_ERR_INFO-1:0] m_err_gray_info1
);

  localparam int ERR_PAD = WD_ERR_INFO - 2 + 0 * NB_VER;
  // A limit that does not fit in the counter could never be reached, so treat it as disabled.
  localparam logic TOUT_EN = (NB_TOUT > 0) && (longint'(NB_TOUT) < (longint'(1) << WD_TOUT));
  localparam logic [WD_TOUT-1:0] TOUT_LIM = TOUT_EN ? WD_TOUT'(NB_TOUT - 1) : '0;
  localparam logic [WD_TOUT-1:0] WD_MAX   = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t                 state_q, state_d;
  logic [WD_TOUT-1:0]     wd_q, wd_d;
  logic [WD_SHK_SYNC-1:0] smosi_q, smosi_d;
  logic [WD_SHK_DLAY-1:0] dmosi_q, dmosi_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WD_SHK_SYNC-1:0] rsp_sync_q, rsp_sync_d;
  logic [WD_SHK_DLAY-1:0] rsp_dlay_q, rsp_dlay_d;
  logic                   rsp_tout_q, rsp_tout_d;
  logic [1:0]             sticky_q, sticky_d;
  logic [WD_ERR_INFO-1:0] err_q, err_d;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    smosi_d     = smosi_q;
    dmosi_d     = dmosi_q;
    rsp_valid_d = 1'b0;
    rsp_sync_d  = rsp_sync_q;
    rsp_dlay_d  = rsp_dlay_q;
    rsp_tout_d  = rsp_tout_q;
    sticky_d    = sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (m_shk_gray_wready) sticky_d[1] = 1'b1;
        if (s_cmd_valid) begin
          smosi_d = s_cmd_sync;
          dmosi_d = s_cmd_dlay;
          wd_d    = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        // Acknowledge is checked first so it wins a tie with the watchdog limit.
        if (m_shk_gray_wready) begin
          rsp_valid_d = 1'b1;
          rsp_sync_d  = m_shk_gray_smiso;
          rsp_dlay_d  = m_shk_gray_dmiso;
          rsp_tout_d  = 1'b0;
          state_d     = ST_GAP;
        end else if (TOUT_EN && (wd_q == TOUT_LIM)) begin
          rsp_valid_d = 1'b1;
          rsp_sync_d  = '0;
          rsp_dlay_d  = '0;
          rsp_tout_d  = 1'b1;
          sticky_d[0] = 1'b1;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (m_shk_gray_wready) sticky_d[1] = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = s_err_gray_info1 | {{ERR_PAD{1'b0}}, sticky_d};
  end

  always_ff @(posedge s_sys_a_clock or negedge s_sys_a_resetn) begin
    if (!s_sys_a_resetn) begin
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      smosi_q     <= '0;
      dmosi_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sync_q  <= '0;
      rsp_dlay_q  <= '0;
      rsp_tout_q  <= 1'b0;
      sticky_q    <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      smosi_q     <= smosi_d;
      dmosi_q     <= dmosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sync_q  <= rsp_sync_d;
      rsp_dlay_q  <= rsp_dlay_d;
      rsp_tout_q  <= rsp_tout_d;
      sticky_q    <= sticky_d;
      err_q       <= err_d;
    end
  end

  assign s_cmd_ready       = (state_q == ST_IDLE);
  assign m_shk_gray_wvalid = (state_q == ST_SEND);
  assign m_shk_gray_smosi  = smosi_q;
  assign m_shk_gray_dmosi  = dmosi_q;
  assign m_rsp_valid       = rsp_valid_q;
  assign m_rsp_sync        = rsp_sync_q;
  assign m_rsp_dlay        = rsp_dlay_q;
  assign m_rsp_tout        = rsp_tout_q;
  assign m_err_gray_info1  = err_q;

endmodule

// File: tb/tb_shk_gray_mstr.sv
// tb/tb_shk_gray_mstr.sv - self-checking bench for shk_gray_mstr with response scoreboard
module tb_shk_gray_mstr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [15:0] s_cmd_sync = '0;
  logic [14:0] s_cmd_dlay = '0;
  logic        m_rsp_valid;
  logic [15:0] m_rsp_sync;
  logic [14:0] m_rsp_dlay;
  logic        m_rsp_tout;
  logic        wvalid;
  logic [15:0] smosi;
  logic [14:0] dmosi;
  logic        wready = 1'b0;
  logic [15:0] smiso = '0;
  logic [14:0] dmiso = '0;
  logic [3:0]  s_err = '0;
  logic [3:0]  m_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] sync;
    logic [14:0] dlay;
    int          dly;
    logic [15:0] smiso;
    logic [14:0] dmiso;
    logic        exp_tout;
    int          exp_whigh;
    logic [15:0] exp_rsync;
    logic [14:0] exp_rdlay;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic [14:0] d;
    logic        t;
  } rsp_t;

  rsp_t sb_q[$];
  int   rsp_seen = 0;
  int   rsp_exp  = 0;

  shk_gray_mstr #(.NB_TOUT(8)) dut (
    .s_sys_a_clock     (clk),
    .s_sys_a_resetn    (rst_n),
    .s_cmd_valid       (s_cmd_valid),
    .s_cmd_ready       (s_cmd_ready),
    .s_cmd_sync        (s_cmd_sync),
    .s_cmd_dlay        (s_cmd_dlay),
    .m_rsp_valid       (m_rsp_valid),
    .m_rsp_sync        (m_rsp_sync),
    .m_rsp_dlay        (m_rsp_dlay),
    .m_rsp_tout        (m_rsp_tout),
    .m_shk_gray_wvalid (wvalid),
    .m_shk_gray_smosi  (smosi),
    .m_shk_gray_dmosi  (dmosi),
    .m_shk_gray_wready (wready),
    .m_shk_gray_smiso  (smiso),
    .m_shk_gray_dmiso  (dmiso),
    .s_err_gray_info1  (s_err),
    .m_err_gray_info1  (m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_rsp_valid) begin
      rsp_t e;
      rsp_seen++;
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_sync", 32'(m_rsp_sync), 32'(e.s));
        chk("rsp_dlay", 32'(m_rsp_dlay), 32'(e.d));
        chk("rsp_tout", 32'(m_rsp_tout), 32'(e.t));
      end
    end
  end

  task automatic do_txn(input vec_t v, input bit keep, output time acc);
    int  w;
    int  hi;
    bit  done;
    rsp_t e;
    s_cmd_sync  = v.sync;
    s_cmd_dlay  = v.dlay;
    s_cmd_valid = 1'b1;
    w = 0;
    while (!s_cmd_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("cmd_ready_wait", 32'(s_cmd_ready), 32'd1);
    e.s = v.exp_rsync; e.d = v.exp_rdlay; e.t = v.exp_tout;
    sb_q.push_back(e);
    rsp_exp++;
    @(posedge clk);
    acc = $time;
    #1;
    if (!keep) s_cmd_valid = 1'b0;
    hi = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k == v.dly) begin
        wready = 1'b1;
        smiso  = v.smiso;
        dmiso  = v.dmiso;
      end
      @(negedge clk);
      if (!wvalid) begin
        done = 1'b1;
      end else begin
        hi++;
        if (smosi !== v.sync) chk("smosi_hold", 32'(smosi), 32'(v.sync));
        if (dmosi !== v.dlay) chk("dmosi_hold", 32'(dmosi), 32'(v.dlay));
        @(posedge clk); #1;
        wready = 1'b0;
      end
    end
    chk("wvalid_high_cycles", 32'(hi), 32'(v.exp_whigh));
    chk("gap_cmd_ready", 32'(s_cmd_ready), 32'd0);
  endtask

  vec_t vecs[5];
  vec_t tv;
  time  t_acc[4];
  time  t_dummy;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h1234, 15'h0055, 2, 16'hBEEF, 15'h7FFF, 1'b0, 3, 16'hBEEF, 15'h7FFF};
    vecs[1] = '{16'hA5A5, 15'h2AAA, 0, 16'h0F0F, 15'h1234, 1'b0, 1, 16'h0F0F, 15'h1234};
    vecs[2] = '{16'h0001, 15'h0001, 7, 16'hCAFE, 15'h4321, 1'b0, 8, 16'hCAFE, 15'h4321};
    vecs[3] = '{16'hFFFF, 15'h7FFF, 5, 16'h8001, 15'h0F0F, 1'b0, 6, 16'h8001, 15'h0F0F};
    vecs[4] = '{16'h5A5A, 15'h1357, -1, 16'hDEAD, 15'h7777, 1'b1, 8, 16'h0000, 15'h0000};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(s_cmd_ready), 32'd1);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_smosi", 32'(smosi), 32'd0);
    chk("rst_dmosi", 32'(dmosi), 32'd0);
    chk("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("rst_rsp_sync", 32'(m_rsp_sync), 32'd0);
    chk("rst_rsp_tout", 32'(m_rsp_tout), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_txn(vecs[i], 1'b0, t_dummy);
      chk("race_err_bit0_clear", 32'(m_err), 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      tv = '{16'h1000 + 16'(i), 15'h0100 + 15'(i), 0, 16'hB000 + 16'(i), 15'h2000 + 15'(i),
             1'b0, 1, 16'hB000 + 16'(i), 15'h2000 + 15'(i)};
      do_txn(tv, 1'b1, t_acc[i]);
    end
    s_cmd_valid = 1'b0;
    for (int i = 1; i < 4; i++)
      chk("b2b_issue_period", 32'(t_acc[i] - t_acc[i-1]), 32'd30);

    s_err = 4'b1000;
    @(posedge clk); #1;
    wready = 1'b1;
    @(posedge clk); #1;
    wready = 1'b0;
    @(negedge clk);
    chk("spurious_err", 32'(m_err), 32'b1010);
    chk("spurious_cmd_ready", 32'(s_cmd_ready), 32'd1);
    chk("spurious_wvalid", 32'(wvalid), 32'd0);
    repeat (2) @(negedge clk);

    do_txn(vecs[4], 1'b0, t_dummy);
    chk("tout_err_bit0", 32'(m_err[0]), 32'd1);
    chk("tout_err_all", 32'(m_err), 32'b1011);
    repeat (4) @(negedge clk);
    chk("tout_err_sticky", 32'(m_err), 32'b1011);

    s_err = 4'b0000;
    @(posedge clk); #1;
    s_cmd_sync  = 16'h7E7E;
    s_cmd_dlay  = 15'h0A0A;
    s_cmd_valid = 1'b1;
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("midsend_wvalid_before_rst", 32'(wvalid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_wvalid", 32'(wvalid), 32'd0);
    chk("midrst_cmd_ready", 32'(s_cmd_ready), 32'd1);
    chk("midrst_smosi", 32'(smosi), 32'd0);
    chk("midrst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("midrst_err", 32'(m_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_err", 32'(m_err), 32'd0);
    do_txn(vecs[0], 1'b0, t_dummy);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("rsp_count", 32'(rsp_seen), 32'(rsp_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shk_gray_mstr.md
# shk_gray_mstr

SHK initiator that drives the gray-drive SHK slave port. It accepts one command at a time from a local request port and issues it as one SHK transaction on the m_shk_gray_* bus. It captures the slave's smiso/dmiso reply and returns it on a response port. A watchdog aborts transactions the slave never acknowledges; timeouts and pass-through errors are reported on the err info chain.

## Interface
- NB_VER, 0: version tag; no functional effect.
- WD_SHK_SYNC, 16: SHK sync (command/status) word width.
- WD_SHK_DLAY, 15: SHK dlay (data) word width.
- WD_TOUT, 16: watchdog counter width.
- NB_TOUT, 1000: watchdog limit in cycles; 0 disables the watchdog.
- WD_ERR_INFO, 4: err info bus width (≥2).
---
- s_sys_a_clock  in  1  single clock for all logic.
- s_sys_a_resetn  in  1  reset, asynchronous assert, active-low.
- s_cmd_valid  in  1  command request.
- s_cmd_ready  out  1  command accepted when high with s_cmd_valid.
- s_cmd_sync  in  WD_SHK_SYNC  sync word to send.
- s_cmd_dlay  in  WD_SHK_DLAY  dlay word to send.
- m_rsp_valid  out  1  one-cycle response strobe.
- m_rsp_sync  out  WD_SHK_SYNC  captured smiso (0 on timeout).
- m_rsp_dlay  out  WD_SHK_DLAY  captured dmiso (0 on timeout).
- m_rsp_tout  out  1  response is a timeout abort.
- m_shk_gray_wvalid  out  1  SHK request.
- m_shk_gray_smosi  out  WD_SHK_SYNC  SHK sync word out.
- m_shk_gray_dmosi  out  WD_SHK_DLAY  SHK dlay word out.
- m_shk_gray_wready  in  1  SHK acknowledge from slave.
- m_shk_gray_smiso  in  WD_SHK_SYNC  slave sync reply, valid with wready.
- m_shk_gray_dmiso  in  WD_SHK_DLAY  slave dlay reply, valid with wready.
- s_err_gray_info1  in  WD_ERR_INFO  upstream errors.
- m_err_gray_info1  out  WD_ERR_INFO  upstream OR local errors, registered.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - s_cmd_ready = 1.
  - On s_cmd_valid, latch sync/dlay into smosi/dmosi registers, set wvalid, clear the watchdog, and go to SEND.
- SEND:
  - s_cmd_ready = 0.
  - wvalid, smosi and dmosi are held constant.
  - Watchdog increments each cycle.
  - wready sampled high: capture smiso/dmiso into m_rsp_sync/m_rsp_dlay, pulse m_rsp_valid with m_rsp_tout=0, clear wvalid, go to GAP.
  - Else, if NB_TOUT≠0 and the watchdog reaches NB_TOUT−1: clear wvalid, pulse m_rsp_valid with m_rsp_tout=1 and rsp data 0, set sticky err bit0, go to GAP.
  - wready wins when it coincides with the watchdog limit.
- GAP: one cycle with wvalid=0 and s_cmd_ready=0, then go to IDLE. This guarantees at least one idle cycle between SHK transactions.
- wready while in IDLE or GAP is ignored; it sets sticky err bit1 (protocol error).
- Error bus: m_err_gray_info1 = s_err_gray_info1 | {0…, bit1, bit0}, registered.
- Sticky bits clear only by reset.
- Watchdog counter is WD_TOUT bits and saturates; it does not wrap.
- NB_TOUT ≥ 2^WD_TOUT behaves as disabled.

## Timing
- Reset values (all outputs 0 except s_cmd_ready):
  - Outputs: wvalid, smosi, dmosi, m_rsp_*, m_err_gray_info1 = 0.
  - s_cmd_ready = 1.
  - FSM = IDLE, watchdog = 0.
- Command accepted at edge N → wvalid=1 from N+1.
- Slave wready sampled at edge M:
  - wvalid=0 and m_rsp_valid=1 during M+1.
  - s_cmd_ready=1 again from M+2.
- Minimum issue period is 3 cycles per transaction when wready arrives in the first SEND cycle.
- Timeout: wvalid stays high exactly NB_TOUT cycles.
- m_rsp_valid is high for exactly 1 cycle. It has no backpressure; the consumer must sample it.
- Reset asserted mid-SEND: wvalid drops immediately (async), the response is lost, and the FSM returns to IDLE. The slave must tolerate wvalid loss under reset.
- Err bits appear on m_err_gray_info1 one cycle after the causing edge.

## Test plan
- **Single transaction:** cmd sync=0x1234, dlay=0x0055; slave answers wready after 3 cycles with smiso=0xBEEF, dmiso=0x7FFF.
  - wvalid high 3 cycles with smosi=0x1234.
  - rsp_valid 1 cycle with rsp_sync=0xBEEF, rsp_dlay=0x7FFF, tout=0.
- **Back-to-back:** s_cmd_valid held high; slave wready in the first cycle each time; 4 commands.
  - 4 transactions, each 3 cycles apart, with ≥1 wvalid-low cycle between them.
  - Responses arrive in order.
- **Timeout:** NB_TOUT=8; slave never asserts wready.
  - wvalid high exactly 8 cycles.
  - rsp_valid with tout=1 and data 0.
  - m_err_gray_info1[0]=1, sticky.
- **Race:** NB_TOUT=8; wready arrives on cycle 8.
  - Normal response with tout=0; err bit0 stays 0.
- **Spurious wready:** wready pulse while IDLE.
  - No rsp_valid.
  - err bit1=1.
  - s_err_gray_info1=4'b1000 → m_err_gray_info1=4'b1010.
- **Reset mid-SEND:** assert reset 2 cycles into SEND, release.
  - All outputs at reset values.
  - No rsp_valid.
  - A new command then completes normally.
